// File: rtl/wave_xfade_selector.sv
// N-channel waveform selector that blends between channels with a linear crossfade
// over 2^FADE_LOG2 sample strobes instead of switching with a hard cut.
module wave_xfade_selector #(
  parameter int DATA_W    = 16,
  parameter int N_CH      = 5,
  parameter int SEL_W     = 3,
  parameter int FADE_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_en,
  input  logic [N_CH*DATA_W-1:0]   wave_in,
  input  logic [SEL_W-1:0]         waveform_sel,
  output logic [DATA_W-1:0]        wave_out,
  output logic                     wave_valid,
  output logic                     busy,
  output logic [SEL_W-1:0]         active_sel,
  output logic                     dbg_state
);

  localparam int N  = 1 << FADE_LOG2;
  localparam int KW = FADE_LOG2 + 1;
  localparam int MW = DATA_W + FADE_LOG2 + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FADE = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [KW-1:0]       r_k;
  logic [KW-1:0]       w_k_nxt;
  logic [SEL_W-1:0]    r_target;
  logic [SEL_W-1:0]    w_target_nxt;
  logic [SEL_W-1:0]    r_active;
  logic [SEL_W-1:0]    w_active_nxt;
  logic [DATA_W-1:0]   r_out;
  logic [DATA_W-1:0]   w_out_nxt;
  logic                r_valid;
  logic                r_busy;
  logic                w_busy_nxt;

  logic [SEL_W-1:0]    w_mix_sel;
  logic [KW-1:0]       w_mix_k;
  logic [KW-1:0]       w_mix_k_inv;
  logic [DATA_W-1:0]   w_ch_act;
  logic [DATA_W-1:0]   w_ch_tgt;
  logic [MW-1:0]       w_sum;
  logic [DATA_W-1:0]   w_mix;

  // In IDLE the blend previews the fade's first step toward the live request.
  assign w_mix_sel   = (r_state == S_IDLE) ? waveform_sel : r_target;
  assign w_mix_k     = (r_state == S_IDLE) ? KW'(1) : (r_k + KW'(1));
  assign w_mix_k_inv = KW'(N) - w_mix_k;

  // Out-of-range selects fall through to silence.
  always_comb begin
    w_ch_act = '0;
    w_ch_tgt = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_active == SEL_W'(i))  w_ch_act = wave_in[i*DATA_W +: DATA_W];
      if (w_mix_sel == SEL_W'(i)) w_ch_tgt = wave_in[i*DATA_W +: DATA_W];
    end
  end

  assign w_sum = (MW'(w_ch_act) * MW'(w_mix_k_inv)) + (MW'(w_ch_tgt) * MW'(w_mix_k));
  assign w_mix = w_sum[FADE_LOG2 +: DATA_W];

  always_comb begin
    w_state_nxt  = r_state;
    w_k_nxt      = r_k;
    w_target_nxt = r_target;
    w_active_nxt = r_active;
    w_out_nxt    = r_out;
    w_busy_nxt   = r_busy;
    if (sample_en) begin
      case (r_state)
        S_IDLE: begin
          if (waveform_sel == r_active) begin
            w_out_nxt = w_ch_act;
          end else begin
            w_target_nxt = waveform_sel;
            w_k_nxt      = KW'(1);
            w_out_nxt    = w_mix;
            if (N == 1) begin
              w_active_nxt = waveform_sel;
            end else begin
              w_state_nxt = S_FADE;
              w_busy_nxt  = 1'b1;
            end
          end
        end
        S_FADE: begin
          w_k_nxt   = w_mix_k;
          w_out_nxt = w_mix;
          if (w_mix_k == KW'(N)) begin
            w_active_nxt = r_target;
            w_busy_nxt   = 1'b0;
            w_state_nxt  = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_target <= '0;
      r_active <= '0;
      r_out    <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_k      <= w_k_nxt;
      r_target <= w_target_nxt;
      r_active <= w_active_nxt;
      r_out    <= w_out_nxt;
      r_valid  <= sample_en;
      r_busy   <= w_busy_nxt;
    end
  end

  assign wave_out   = r_out;
  assign wave_valid = r_valid;
  assign busy       = r_busy;
  assign active_sel = r_active;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_wave_xfade_selector.sv
// Bench for wave_xfade_selector: directed fade scenarios plus random selects,
// checked against a behavioural crossfade model through an expected-value queue.
module tb_wave_xfade_selector;

  localparam int DATA_W    = 16;
  localparam int N_CH      = 5;
  localparam int SEL_W     = 3;
  localparam int FADE_LOG2 = 2;
  localparam int NF        = 4;
  localparam int EW        = DATA_W + 1 + SEL_W;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   sample_en = 1'b0;
  logic [N_CH*DATA_W-1:0] wave_in = '0;
  logic [SEL_W-1:0]       waveform_sel = '0;
  logic [DATA_W-1:0]      wave_out;
  logic                   wave_valid;
  logic                   busy;
  logic [SEL_W-1:0]       active_sel;
  logic                   dbg_state;

  wave_xfade_selector #(
    .DATA_W(DATA_W), .N_CH(N_CH), .SEL_W(SEL_W), .FADE_LOG2(FADE_LOG2)
  ) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .wave_in(wave_in),
    .waveform_sel(waveform_sel), .wave_out(wave_out), .wave_valid(wave_valid),
    .busy(busy), .active_sel(active_sel), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int n_compared = 0;
  int n_failed   = 0;
  logic se_d  = 1'b0;
  logic rst_d = 1'b1;
  logic [DATA_W-1:0] last_out = '0;

  // behavioural model
  int m_active = 0;
  int m_target = 0;
  int m_k      = 0;
  bit m_fading = 0;

  function automatic int chv(input int sel, input logic [N_CH*DATA_W-1:0] w);
    if (sel < N_CH) return int'(w[sel*DATA_W +: DATA_W]);
    return 0;
  endfunction

  function automatic int blend(input int a, input int b, input int k);
    longint t;
    t = longint'(a) * (NF - k) + longint'(b) * k;
    return int'(t / NF);
  endfunction

  task automatic model_sample(input int sel, input logic [N_CH*DATA_W-1:0] w);
    int o;
    if (!m_fading) begin
      if (sel == m_active) begin
        o = chv(m_active, w);
      end else begin
        m_target = sel;
        m_k = 1;
        o = blend(chv(m_active, w), chv(m_target, w), m_k);
        if (NF == 1) m_active = sel;
        else m_fading = 1;
      end
    end else begin
      m_k = m_k + 1;
      o = blend(chv(m_active, w), chv(m_target, w), m_k);
      if (m_k == NF) begin
        m_active = m_target;
        m_fading = 0;
      end
    end
    exp_q.push_back({o[DATA_W-1:0], m_fading, m_active[SEL_W-1:0]});
  endtask

  task automatic model_reset();
    m_active = 0;
    m_target = 0;
    m_k      = 0;
    m_fading = 0;
  endtask

  // driver tasks: entered and left at a falling edge
  task automatic drive_sample(input int sel, input logic [N_CH*DATA_W-1:0] w, input int gap);
    wave_in      = w;
    waveform_sel = sel[SEL_W-1:0];
    sample_en    = 1'b1;
    model_sample(sel, w);
    @(negedge clk);
    sample_en = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      sample_en    = 1'($urandom_range(0, 1));
      waveform_sel = SEL_W'($urandom_range(0, 7));
      @(negedge clk);
    end
    rst       = 1'b0;
    sample_en = 1'b0;
    model_reset();
  endtask

  function automatic logic [N_CH*DATA_W-1:0] pack5(input int c0, input int c1,
                                                   input int c2, input int c3, input int c4);
    return {c4[15:0], c3[15:0], c2[15:0], c1[15:0], c0[15:0]};
  endfunction

  // monitor
  always @(posedge clk) begin
    rst_d <= rst;
    se_d  <= sample_en && !rst;
  end

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_d) begin
      n_compared++;
      if ({wave_out, wave_valid, busy, active_sel} != '0) begin
        n_failed++;
        $display("FAIL reset: out=%h valid=%b busy=%b act=%0d, required all zero",
                 wave_out, wave_valid, busy, active_sel);
      end
      last_out = '0;
    end else begin
      n_compared++;
      if (wave_valid !== se_d) begin
        n_failed++;
        $display("FAIL valid_timing: got %b required %b at %0t", wave_valid, se_d, $time);
      end
      if (wave_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_failed++;
          $display("FAIL unexpected_output: out=%h with no pending sample", wave_out);
        end else begin
          e = exp_q.pop_front();
          n_compared++;
          if ({wave_out, busy, active_sel} !== e) begin
            n_failed++;
            $display("FAIL sample: got out=%h busy=%b act=%0d required out=%h busy=%b act=%0d at %0t",
                     wave_out, busy, active_sel, e[EW-1 -: DATA_W], e[SEL_W], e[SEL_W-1:0], $time);
          end
          last_out = e[EW-1 -: DATA_W];
        end
      end else begin
        n_compared++;
        if (wave_out !== last_out) begin
          n_failed++;
          $display("FAIL hold: out=%h required %h at %0t", wave_out, last_out, $time);
        end
      end
    end
  end

  // stimulus
  logic [N_CH*DATA_W-1:0] w;
  initial begin
    @(negedge clk);
    do_reset(3);

    // steady select
    w = pack5(16'h1000, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    for (int i = 0; i < 3; i++) drive_sample(0, w, 2);

    // fade up 0 -> 1, with a select change to 3 during the fade
    w = pack5(16'h0000, 16'hFFFF, 16'h0123, 16'h2000, 16'h0456);
    drive_sample(1, w, 0);
    drive_sample(1, w, 1);
    drive_sample(3, w, 0);
    drive_sample(3, w, 1);
    drive_sample(3, w, 0);
    for (int i = 0; i < 3; i++) drive_sample(3, w, 0);
    drive_sample(3, w, 1);

    // invalid select fades to silence
    do_reset(1);
    w = pack5(16'h8000, 16'h5555, 16'h6666, 16'h7777, 16'h9999);
    for (int i = 0; i < 6; i++) drive_sample(7, w, $urandom_range(0, 1));

    // reset mid-fade then restart
    do_reset(2);
    w = pack5(16'h0000, 16'hFFFF, 16'h1234, 16'h5678, 16'h9ABC);
    drive_sample(1, w, 0);
    drive_sample(1, w, 0);
    do_reset(1);
    for (int i = 0; i < 4; i++) drive_sample(1, w, 0);

    // random selects and moving waveforms
    for (int n = 0; n < 400; n++) begin
      int sel;
      if ($urandom_range(0, 99) < 2) do_reset($urandom_range(1, 3));
      for (int c = 0; c < N_CH; c++) w[c*DATA_W +: DATA_W] = DATA_W'($urandom);
      sel = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : m_active;
      drive_sample(sel, w, $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    n_compared++;
    if (exp_q.size() != 0) begin
      n_failed++;
      $display("FAIL drain: %0d outputs never appeared, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
